nibble_add_sequencer: RTL and testbench

- Sequencer and arbiter that shares one external 4-bit carry-lookahead adder slice between two requesters.
- Performs WIDTH-bit additions nibble-serially, least-significant nibble first, and holds the inter-nibble carry in a register.
- Sits between the requesting datapath blocks and the existing 4-bit lookahead adder cell. The adder stays purely combinational; this block supplies all sequencing.

---
 rtl/nibble_add_sequencer.sv | 165 ++++++++++++++++
 tb/tb_nibble_add_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: round-robin arbiter and sequencer sharing one external
// 4-bit lookahead adder slice between two requesters. Each WIDTH-bit operation
// takes NIBBLES passes, least-significant nibble first, with the inter-nibble
// carry held in a register.
// Optional feature macro: NIBBLE_ADD_SEQ_SUB_EN adds sub0/sub1 inputs that
// select A-B (via ~B and an initial carry of 1) instead of A+B.
module nibble_add_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
   input  logic             sub0,
   input  logic             sub1,
`endif
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             owner,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_b_q, work_q, work_d, sum_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q, cout_q, owner_q, cur_q, prio1_q, sub_q;
   logic               gnt0_q, gnt1_q;
   logic               req_any, grant_sel, sub_sel, last_nib;
   logic [3:0]         nib_a, nib_b;

   assign req_any   = req0 | req1;
   // req1 wins when it is alone, or when both pend and req0 was served last.
   assign grant_sel = req1 & (~req0 | prio1_q);
   assign last_nib  = (idx_q == IDX_W'(NIBBLES - 1));

`ifdef NIBBLE_ADD_SEQ_SUB_EN
   assign sub_sel = grant_sel ? sub1 : sub0;
`else
   assign sub_sel = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_any) state_d = StRun;
         StRun:   if (last_nib) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Select the current operand nibbles and merge the slice sum into the working result.
   always_comb begin
      nib_a  = 4'h0;
      nib_b  = 4'h0;
      work_d = work_q;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_a              = op_a_q[4*i +: 4];
            nib_b              = op_b_q[4*i +: 4];
            work_d[4*i +: 4]   = add_s;
         end
      end
   end

   // Adder slice drive: only active in RUN, quiet zeros otherwise.
   always_comb begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      if (state_q == StRun) begin
         add_a   = nib_a;
         add_b   = sub_q ? ~nib_b : nib_b;
         add_cin = carry_q;
      end
   end

   // Datapath: operand capture at grant, nibble-serial accumulate, result publish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         owner_q <= 1'b0;
         cur_q   <= 1'b0;
         prio1_q <= 1'b0;
         sub_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_any) begin
                  op_a_q  <= grant_sel ? a1 : a0;
                  op_b_q  <= grant_sel ? b1 : b0;
                  sub_q   <= sub_sel;
                  // Fresh carry every operation; subtraction seeds the +1 of two's complement.
                  carry_q <= sub_sel;
                  idx_q   <= '0;
                  cur_q   <= grant_sel;
                  prio1_q <= ~grant_sel;
                  gnt0_q  <= ~grant_sel;
                  gnt1_q  <= grant_sel;
               end
            end
            StRun: begin
               work_q  <= work_d;
               carry_q <= add_cout;
               if (last_nib) begin
                  idx_q   <= '0;
                  sum_q   <= work_d;
                  cout_q  <= add_cout;
                  owner_q <= cur_q;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign busy  = (state_q != StIdle);
   assign done  = (state_q == StDone);
   assign owner = owner_q;
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer with a behavioural 4-bit adder slice.
// Build with +define+NIBBLE_ADD_SEQ_SUB_EN to also exercise subtraction.
module tb_nibble_add_sequencer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
   logic          sub0 = 1'b0, sub1 = 1'b0;
`endif
   logic          gnt0, gnt1, busy, done, owner, cout;
   logic [W-1:0]  sum;
   logic [3:0]    add_a, add_b, add_s;
   logic          add_cin, add_cout;

   typedef struct {
      logic         owner;
      logic [W-1:0] sum;
      logic         cout;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   nibble_add_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      .sub0(sub0), .sub1(sub1),
`endif
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .owner(owner),
      .sum(sum), .cout(cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout)
   );

   // External combinational adder slice.
   assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   always #5 clk = ~clk;

   function automatic exp_t make_exp(input logic who, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic sub);
      logic [W:0] t;
      exp_t e;
      t = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (W+1)'(sub);
      e.owner = who;
      e.sum   = t[W-1:0];
      e.cout  = t[W];
      return e;
   endfunction

   // Drives one request, pushes its expectation, waits (bounded) for grant and done.
   task automatic do_op(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output int glat, output int dlat,
                        output logic [W-1:0] s, output logic c, output logic o);
      glat = -1;
      dlat = -1;
      s = 'x;
      c = 1'bx;
      o = 1'bx;
      if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
      else     begin req0 = 1'b1; a0 = a; b0 = b; end
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      if (who) sub1 = sub; else sub0 = sub;
`endif
      sb.push_back(make_exp(who, a, b, sub));
      for (int n = 1; n <= 40 && dlat < 0; n++) begin
         @(negedge clk);
         if (glat < 0 && (who ? gnt1 : gnt0)) begin
            glat = n;
            if (who) req1 = 1'b0; else req0 = 1'b0;
         end
         if (done) begin
            dlat = n;
            s = sum;
            c = cout;
            o = owner;
         end
      end
      if (dlat < 0) begin
         checks++;
         errors++;
         $display("FAIL op_timeout who=%0d: no done within 40 cycles", who);
         req0 = 1'b0;
         req1 = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, busy, done, owner, cout, add_cin} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=0000000",
                  {gnt0, gnt1, busy, done, owner, cout, add_cin});
      end
      checks++;
      if ({sum, add_a, add_b} !== '0) begin
         errors++;
         $display("FAIL reset_data sum=%h add_a=%h add_b=%h want all 0", sum, add_a, add_b);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // FFFF + 0001: carry ripples from nibble 0 through nibble 3.
   task automatic test_carry();
      logic [3:0] cins;
      int         run_n, dn;
      exp_t       e;
      cins  = 4'h0;
      run_n = 0;
      dn    = 0;
      req1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001;
      sb.push_back(make_exp(1'b1, 16'hFFFF, 16'h0001, 1'b0));
      for (int n = 0; n < 20 && dn == 0; n++) begin
         @(negedge clk);
         if (gnt1) req1 = 1'b0;
         if (busy && !done && run_n < 4) begin
            cins[run_n] = add_cin;
            run_n++;
         end
         if (done) begin
            dn = 1;
            e = sb.pop_front();
            checks++;
            if (sum !== e.sum || cout !== e.cout || owner !== e.owner) begin
               errors++;
               $display("FAIL carry_result got sum=%h cout=%b owner=%b want %h %b %b",
                        sum, cout, owner, e.sum, e.cout, e.owner);
            end
         end
      end
      req1 = 1'b0;
      checks++;
      if (dn == 0) begin
         errors++;
         $display("FAIL carry_done got none want done pulse");
         sb.delete();
      end
      checks++;
      if (cins !== 4'b1110 || run_n != 4) begin
         errors++;
         $display("FAIL carry_cin_seq got=%b (%0d passes) want=1110 (4 passes)", cins, run_n);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      int glat, dlat;
      logic [W-1:0] s;
      logic c, o;
      exp_t e;
      do_op(1'b0, 16'h1234, 16'h4321, 1'b0, glat, dlat, s, c, o);
      e = sb.pop_front();
      checks++;
      if (glat != 1 || dlat != 5) begin
         errors++;
         $display("FAIL basic_latency got gnt=%0d done=%0d want gnt=1 done=5", glat, dlat);
      end
      checks++;
      if (s !== e.sum || c !== e.cout || o !== e.owner) begin
         errors++;
         $display("FAIL basic_result got %h %b %b want %h %b %b", s, c, o, e.sum, e.cout, e.owner);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int   gcyc[3];
      logic gwho[3];
      int   ng, nd;
      exp_t e;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ng = 0;
      nd = 0;
      a0 = 16'h0102; b0 = 16'h0304;
      a1 = 16'h1000; b1 = 16'h2000;
      req0 = 1'b1; req1 = 1'b1;
      sb.push_back(make_exp(1'b0, a0, b0, 1'b0));
      sb.push_back(make_exp(1'b1, a1, b1, 1'b0));
      sb.push_back(make_exp(1'b0, a0, b0, 1'b0));
      for (int n = 1; n <= 40 && nd < 3; n++) begin
         @(negedge clk);
         if ((gnt0 || gnt1) && ng < 3) begin
            gcyc[ng] = n;
            gwho[ng] = gnt1;
            ng++;
            if (ng == 3) begin req0 = 1'b0; req1 = 1'b0; end
         end
         if (done && sb.size() > 0) begin
            e = sb.pop_front();
            nd++;
            checks++;
            if (sum !== e.sum || owner !== e.owner) begin
               errors++;
               $display("FAIL rr_result%0d got sum=%h owner=%b want %h %b",
                        nd, sum, owner, e.sum, e.owner);
            end
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checks++;
      if (ng != 3 || nd != 3) begin
         errors++;
         $display("FAIL rr_count got grants=%0d dones=%0d want 3 3", ng, nd);
         sb.delete();
      end else begin
         checks++;
         if ({gwho[0], gwho[1], gwho[2]} !== 3'b010) begin
            errors++;
            $display("FAIL rr_order got=%b%b%b want=010", gwho[0], gwho[1], gwho[2]);
         end
         checks++;
         if (gcyc[1] - gcyc[0] != 6 || gcyc[2] - gcyc[1] != 6) begin
            errors++;
            $display("FAIL rr_spacing got %0d,%0d want 6,6", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int   glat, dlat, seen_done, got_g;
      logic [W-1:0] s;
      logic c, o;
      exp_t e;
      got_g = 0;
      seen_done = 0;
      req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222;
      for (int n = 0; n < 10 && got_g == 0; n++) begin
         @(negedge clk);
         if (gnt0) got_g = 1;
      end
      req0 = 1'b0;
      checks++;
      if (got_g == 0) begin
         errors++;
         $display("FAIL mid_gnt got none want gnt0");
      end
      // Grant cycle is index 0; two more cycles reach index 2.
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, gnt0, gnt1, owner, cout, add_cin} !== 7'b0 ||
          {sum, add_a, add_b} !== '0) begin
         errors++;
         $display("FAIL mid_async_reset busy=%b done=%b sum=%h add_a=%h want all 0",
                  busy, done, sum, add_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL mid_no_done got done pulse want none");
      end
      do_op(1'b1, 16'h00F0, 16'h0010, 1'b0, glat, dlat, s, c, o);
      e = sb.pop_front();
      checks++;
      if (s !== e.sum || c !== e.cout || o !== e.owner) begin
         errors++;
         $display("FAIL mid_after_result got %h %b %b want %h %b %b",
                  s, c, o, e.sum, e.cout, e.owner);
      end
      @(negedge clk);
   endtask

   task automatic test_done_rise();
      int   glat, dlat, dn;
      logic [W-1:0] s;
      logic c, o;
      exp_t e;
      do_op(1'b0, 16'h0101, 16'h0202, 1'b0, glat, dlat, s, c, o);
      e = sb.pop_front();
      checks++;
      if (s !== e.sum) begin
         errors++;
         $display("FAIL rise_first got %h want %h", s, e.sum);
      end
      // Still in the DONE cycle: raise a new request.
      req0 = 1'b1; a0 = 16'h1000; b0 = 16'h0001;
      sb.push_back(make_exp(1'b0, a0, b0, 1'b0));
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rise_idle got gnt0=%b busy=%b want 0 0", gnt0, busy);
      end
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || sum !== 16'h0303) begin
         errors++;
         $display("FAIL rise_gnt got gnt0=%b sum=%h want 1 0303", gnt0, sum);
      end
      req0 = 1'b0;
      dn = 0;
      for (int n = 0; n < 10 && dn == 0; n++) begin
         @(negedge clk);
         if (!done && sum !== 16'h0303) begin
            checks++;
            errors++;
            $display("FAIL rise_hold got sum=%h want 0303 before done", sum);
         end
         if (done) dn = 1;
      end
      e = sb.pop_front();
      checks++;
      if (dn == 0 || sum !== e.sum || owner !== e.owner) begin
         errors++;
         $display("FAIL rise_second got done=%0d sum=%h want 1 %h", dn, sum, e.sum);
      end
      @(negedge clk);
   endtask

`ifdef NIBBLE_ADD_SEQ_SUB_EN
   task automatic test_sub();
      int   glat, dlat;
      logic [W-1:0] s;
      logic c, o;
      exp_t e;
      do_op(1'b0, 16'h0005, 16'h0007, 1'b1, glat, dlat, s, c, o);
      e = sb.pop_front();
      checks++;
      if (s !== e.sum || c !== e.cout) begin
         errors++;
         $display("FAIL sub_borrow got %h %b want %h %b", s, c, e.sum, e.cout);
      end
      @(negedge clk);
      do_op(1'b0, 16'h0009, 16'h0003, 1'b1, glat, dlat, s, c, o);
      e = sb.pop_front();
      checks++;
      if (s !== e.sum || c !== e.cout) begin
         errors++;
         $display("FAIL sub_noborrow got %h %b want %h %b", s, c, e.sum, e.cout);
      end
      sub0 = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_carry();
      test_basic();
      test_round_robin();
      test_reset_mid();
      test_done_rise();
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      test_sub();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
